// File: rtl/pe_row_gen.sv
// pe_row_gen: a row of signed MAC lanes that share one broadcast feature
// stream, each with its own weight scratchpad and saturating accumulator.
module pe_row_gen #(
  parameter int NUM_PE     = 16,
  parameter int FEAT_WIDTH = 8,
  parameter int WGT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int K_MAX      = 64,
  localparam int KW = $clog2(K_MAX + 1),
  localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [KW-1:0]               cfg_k,
  input  logic                        acc_keep,
  input  logic                        start,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [PW-1:0]               w_pe,
  input  logic [AW-1:0]               w_addr,
  input  logic [WGT_WIDTH-1:0]        w_data,
  input  logic                        f_valid,
  output logic                        f_ready,
  input  logic [FEAT_WIDTH-1:0]       f_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_PE*ACC_WIDTH-1:0] out_data,
  output logic [NUM_PE-1:0]           out_ovf,
  output logic                        busy,
  output logic                        err
);

  localparam int PRW = FEAT_WIDTH + WGT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_e;

  state_e state_q, state_d;

  logic signed [WGT_WIDTH-1:0] wmem_q [NUM_PE][K_MAX];
  logic signed [ACC_WIDTH-1:0] acc_q  [NUM_PE];
  logic signed [ACC_WIDTH-1:0] acc_d  [NUM_PE];
  logic signed [PRW-1:0]       prod   [NUM_PE];
  logic signed [ACC_WIDTH:0]   sum    [NUM_PE];

  logic [NUM_PE-1:0] ovf_q, clamp;
  logic [KW-1:0]     k_q, cnt_q;
  logic              err_q;
  logic              in_idle, cfg_ok, start_go, start_bad;
  logic              beat, last, wr_en;
  logic [AW-1:0]     widx;
  logic signed [FEAT_WIDTH-1:0] feat;

  assign in_idle   = reset && (state_q == IDLE);
  assign w_ready   = in_idle;
  assign f_ready   = reset && (state_q == COMPUTE);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign out_ovf   = ovf_q;

  assign cfg_ok    = (cfg_k != '0) && (cfg_k <= KW'(K_MAX));
  assign start_go  = in_idle && start && cfg_ok;
  assign start_bad = in_idle && start && !cfg_ok;
  assign beat      = f_valid && f_ready;
  assign last      = ((cnt_q + KW'(1)) == k_q);
  assign widx      = cnt_q[AW-1:0];
  assign feat      = f_data;

  // Out-of-range lane or address writes are silently dropped.
  assign wr_en = w_valid && w_ready
              && ({1'b0, w_pe} < (PW+1)'(NUM_PE))
              && ({1'b0, w_addr} < (AW+1)'(K_MAX));

  for (genvar g = 0; g < NUM_PE; g++) begin : g_out
    assign out_data[ACC_WIDTH*g +: ACC_WIDTH] = acc_q[g];
  end

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      prod[i]  = PRW'(feat) * PRW'(wmem_q[i][widx]);
      sum[i]   = (ACC_WIDTH+1)'(acc_q[i]) + (ACC_WIDTH+1)'(prod[i]);
      clamp[i] = sum[i][ACC_WIDTH] != sum[i][ACC_WIDTH-1];
      if (!clamp[i])
        acc_d[i] = sum[i][ACC_WIDTH-1:0];
      else if (sum[i][ACC_WIDTH])
        acc_d[i] = ACC_MIN;
      else
        acc_d[i] = ACC_MAX;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_go) state_d = COMPUTE;
      COMPUTE: if (beat && last) state_d = DRAIN;
      DRAIN:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PE; i++) acc_q[i] <= '0;
      ovf_q <= '0;
      k_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_go) begin
        k_q   <= cfg_k;
        cnt_q <= '0;
        if (!acc_keep) begin
          for (int i = 0; i < NUM_PE; i++) acc_q[i] <= '0;
          ovf_q <= '0;
        end
      end
      if (beat) begin
        cnt_q <= cnt_q + KW'(1);
        for (int i = 0; i < NUM_PE; i++) acc_q[i] <= acc_d[i];
        ovf_q <= ovf_q | clamp;
      end
    end
  end

  // Scratchpads hold weights across resets; only explicit writes change them.
  always_ff @(posedge clk) begin
    if (wr_en) wmem_q[w_pe][w_addr] <= w_data;
  end

endmodule

// File: tb/tb_pe_row_gen.sv
// Randomized bench for pe_row_gen against an integer reference model
// of the lane accumulators, saturation flags and weight scratchpads.
module tb_pe_row_gen;

  localparam int NP = 4;
  localparam int KM = 8;
  localparam int AC = 16;
  localparam int AMAX = 32767;
  localparam int AMIN = -32768;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    cfg_k;
  logic          acc_keep, start;
  logic          w_valid, w_ready;
  logic [1:0]    w_pe;
  logic [2:0]    w_addr;
  logic [7:0]    w_data;
  logic          f_valid, f_ready;
  logic [7:0]    f_data;
  logic          out_valid, out_ready;
  logic [63:0]   out_data;
  logic [3:0]    out_ovf;
  logic          busy, err;

  always #5 clk = ~clk;

  pe_row_gen #(
    .NUM_PE(NP), .FEAT_WIDTH(8), .WGT_WIDTH(8),
    .ACC_WIDTH(AC), .K_MAX(KM)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_k(cfg_k), .acc_keep(acc_keep), .start(start),
    .w_valid(w_valid), .w_ready(w_ready),
    .w_pe(w_pe), .w_addr(w_addr), .w_data(w_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf),
    .busy(busy), .err(err)
  );

  int ntests = 0;
  int nfail  = 0;

  int mw   [NP][KM];
  int macc [NP];
  bit movf [NP];
  int pat  [6] = '{1, 0, 0, 1, 0, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; cfg_k = '0; acc_keep = 0;
    w_valid = 0; w_pe = '0; w_addr = '0; w_data = '0;
    f_valid = 0; f_data = '0; out_ready = 0;
  endtask

  task automatic wr(input int pe, input int a, input int d);
    w_valid = 1; w_pe = 2'(pe); w_addr = 3'(a); w_data = 8'(d);
    tick();
    w_valid = 0;
    mw[pe][a] = d;
  endtask

  function automatic int rs8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      macc[i] = 0; movf[i] = 0;
    end
  endtask

  task automatic model_pass(input int k, input bit keep, input int f[KM]);
    if (!keep) model_clear();
    for (int n = 0; n < k; n++)
      for (int i = 0; i < NP; i++) begin
        int s;
        s = macc[i] + f[n] * mw[i][n];
        if (s > AMAX) begin s = AMAX; movf[i] = 1; end
        if (s < AMIN) begin s = AMIN; movf[i] = 1; end
        macc[i] = s;
      end
  endtask

  function automatic logic [63:0] exp_data();
    logic [63:0] r;
    for (int i = 0; i < NP; i++) r[16*i +: 16] = 16'(macc[i]);
    return r;
  endfunction

  function automatic logic [3:0] exp_ovf();
    logic [3:0] r;
    for (int i = 0; i < NP; i++) r[i] = movf[i];
    return r;
  endfunction

  // Runs one pass; proto bits = {latency, busy/err, stable, back-to-idle}.
  task automatic do_pass(input int k, input bit keep, input int f[KM],
                         input int mode, input int hold,
                         output logic [63:0] d, output logic [3:0] o,
                         output logic [3:0] proto);
    int j = 0;
    int cyc = 0;
    bit acc;
    proto = 4'hF;
    cfg_k = 4'(k); acc_keep = keep; start = 1;
    tick();
    start = 0;
    while (j < k && cyc < 200) begin
      case (mode)
        0:       f_valid = 1;
        1:       f_valid = (pat[cyc % 6] != 0);
        default: f_valid = 1'($urandom_range(0, 1));
      endcase
      f_data = 8'(f[j]);
      acc = f_valid && f_ready;
      if (out_valid) proto[3] = 0;
      if (!busy || err) proto[2] = 0;
      tick();
      cyc++;
      if (acc) j++;
    end
    f_valid = 0;
    if (j < k || !out_valid) proto[3] = 0;
    d = out_data; o = out_ovf;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (out_data !== d || out_ovf !== o || !out_valid) proto[1] = 0;
      if (!busy || err) proto[2] = 0;
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    if (out_valid || busy) proto[0] = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    w_valid = 1;
    tick(); tick();
    ntests++;
    if ({w_ready, f_ready} !== 2'b00) begin
      nfail++;
      $display("FAIL rst_ready got %b exp 00", {w_ready, f_ready});
    end
    ntests++;
    if ({out_valid, busy, err, out_ovf, out_data} !== '0) begin
      nfail++;
      $display("FAIL rst_outs got v%b b%b e%b o%h d%h exp all 0",
               out_valid, busy, err, out_ovf, out_data);
    end
    w_valid = 0;
    reset = 1;
    tick();
    ntests++;
    if ({w_ready, f_ready} !== 2'b10) begin
      nfail++;
      $display("FAIL rst_release got %b exp 10", {w_ready, f_ready});
    end
    model_clear();
  endtask

  task automatic test_basic();
    int f[KM];
    logic [63:0] d; logic [3:0] o; logic [3:0] p;
    for (int i = 0; i < NP; i++)
      for (int n = 0; n < 3; n++) wr(i, n, i + 1);
    f = '{2, 3, 4, 0, 0, 0, 0, 0};
    do_pass(3, 0, f, 0, 0, d, o, p);
    model_pass(3, 0, f);
    ntests++;
    if (d !== exp_data()) begin
      nfail++; $display("FAIL basic_data got %h exp %h", d, exp_data());
    end
    ntests++;
    if (p !== 4'hF) begin
      nfail++; $display("FAIL basic_proto got %b exp 1111", p);
    end
    do_pass(3, 1, f, 0, 0, d, o, p);
    model_pass(3, 1, f);
    ntests++;
    if ({o, d} !== {exp_ovf(), exp_data()}) begin
      nfail++;
      $display("FAIL multipass got %h/%h exp %h/%h",
               o, d, exp_ovf(), exp_data());
    end
  endtask

  task automatic test_saturation();
    int f[KM];
    logic [63:0] d; logic [3:0] o; logic [3:0] p;
    for (int n = 0; n < KM; n++) begin
      wr(0, n, 127);
      for (int i = 1; i < NP; i++) wr(i, n, rs8());
      f[n] = 127;
    end
    do_pass(KM, 0, f, 0, 1, d, o, p);
    model_pass(KM, 0, f);
    ntests++;
    if ({o[0], d[15:0]} !== {1'b1, 16'h7FFF}) begin
      nfail++;
      $display("FAIL sat_lane0 got o%b %h exp o1 7fff", o[0], d[15:0]);
    end
    ntests++;
    if ({o, d} !== {exp_ovf(), exp_data()}) begin
      nfail++;
      $display("FAIL sat_all got %h/%h exp %h/%h",
               o, d, exp_ovf(), exp_data());
    end
    f[0] = 1;
    do_pass(1, 0, f, 0, 0, d, o, p);
    model_pass(1, 0, f);
    ntests++;
    if ({o, d} !== {exp_ovf(), exp_data()}) begin
      nfail++;
      $display("FAIL sat_clear got %h/%h exp %h/%h",
               o, d, exp_ovf(), exp_data());
    end
  endtask

  task automatic test_stall();
    int f[KM];
    logic [63:0] d; logic [3:0] o; logic [3:0] p;
    for (int n = 0; n < KM; n++) f[n] = rs8();
    do_pass(3, 0, f, 1, 5, d, o, p);
    model_pass(3, 0, f);
    ntests++;
    if ({o, d} !== {exp_ovf(), exp_data()}) begin
      nfail++;
      $display("FAIL stall_data got %h/%h exp %h/%h",
               o, d, exp_ovf(), exp_data());
    end
    ntests++;
    if (p !== 4'hF) begin
      nfail++; $display("FAIL stall_proto got %b exp 1111", p);
    end
  endtask

  task automatic test_illegal();
    int f[KM];
    logic [1:0] e;
    cfg_k = 4'd0; start = 1;
    tick();
    start = 0;
    e[1] = err; e[0] = busy;
    tick();
    ntests++;
    if ({e, err, busy} !== 4'b1000) begin
      nfail++;
      $display("FAIL err_k0 got %b exp 1000", {e, err, busy});
    end
    cfg_k = 4'd9; start = 1;
    tick();
    start = 0;
    e[1] = err; e[0] = busy;
    tick();
    ntests++;
    if ({e, err, busy, out_data} !== {4'b1000, exp_data()}) begin
      nfail++;
      $display("FAIL err_k9 got %b %h exp 1000 %h",
               {e, err, busy}, out_data, exp_data());
    end
    // Start and write while computing must both be ignored.
    f[0] = rs8(); f[1] = rs8();
    cfg_k = 4'd2; acc_keep = 0; start = 1;
    tick();
    f_valid = 1; start = 0; f_data = 8'(f[0]);
    tick();
    f_valid = 0; start = 1; cfg_k = 4'd5;
    w_valid = 1; w_pe = 2'd0; w_addr = 3'd1; w_data = 8'd99;
    e[1] = w_ready; e[0] = err;
    tick();
    start = 0; w_valid = 0;
    f_valid = 1; f_data = 8'(f[1]);
    tick();
    f_valid = 0;
    model_pass(2, 0, f);
    ntests++;
    if ({e, out_valid, out_data} !== {3'b001, exp_data()}) begin
      nfail++;
      $display("FAIL busy_ignore got %b %h exp 001 %h",
               {e, out_valid}, out_data, exp_data());
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    // Start with a simultaneous write: the new weight is used.
    f[0] = rs8();
    cfg_k = 4'd1; acc_keep = 0; start = 1;
    w_valid = 1; w_pe = 2'd2; w_addr = 3'd0; w_data = 8'(-77);
    tick();
    mw[2][0] = -77;
    start = 0; w_valid = 0;
    f_valid = 1; f_data = 8'(f[0]);
    tick();
    f_valid = 0;
    model_pass(1, 0, f);
    ntests++;
    if ({out_valid, out_data} !== {1'b1, exp_data()}) begin
      nfail++;
      $display("FAIL start_wr got v%b %h exp v1 %h",
               out_valid, out_data, exp_data());
    end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset_mid();
    int f[KM];
    logic [63:0] d; logic [3:0] o; logic [3:0] p;
    for (int n = 0; n < KM; n++) f[n] = rs8();
    cfg_k = 4'd3; acc_keep = 1; start = 1;
    tick();
    start = 0; f_valid = 1;
    f_data = 8'(f[0]); tick();
    f_data = 8'(f[1]); tick();
    f_data = 8'(f[2]); reset = 0;
    tick();
    reset = 1; f_valid = 0;
    model_clear();
    ntests++;
    if ({out_valid, busy, out_ovf, out_data} !== '0) begin
      nfail++;
      $display("FAIL rst_mid got v%b b%b o%h d%h exp all 0",
               out_valid, busy, out_ovf, out_data);
    end
    tick();
    do_pass(3, 0, f, 0, 0, d, o, p);
    model_pass(3, 0, f);
    ntests++;
    if ({p, o, d} !== {4'hF, exp_ovf(), exp_data()}) begin
      nfail++;
      $display("FAIL rst_fresh got %b %h/%h exp 1111 %h/%h",
               p, o, d, exp_ovf(), exp_data());
    end
  endtask

  task automatic test_random();
    int f[KM];
    int k;
    bit keep;
    logic [63:0] d; logic [3:0] o; logic [3:0] p;
    for (int it = 0; it < 24; it++) begin
      for (int w = 0; w < 6; w++)
        wr($urandom_range(0, NP-1), $urandom_range(0, KM-1), rs8());
      k = $urandom_range(1, KM);
      keep = 1'($urandom_range(0, 1));
      for (int n = 0; n < KM; n++) f[n] = rs8();
      do_pass(k, keep, f, 2, $urandom_range(0, 3), d, o, p);
      model_pass(k, keep, f);
      ntests++;
      if ({p, o, d} !== {4'hF, exp_ovf(), exp_data()}) begin
        nfail++;
        $display("FAIL rand%0d k%0d got %b %h/%h exp 1111 %h/%h",
                 it, k, p, o, d, exp_ovf(), exp_data());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
